// File: rtl/spart_pkg.sv
// Shared constants and state types for the SPART serial engine.
package spart_pkg;

  localparam logic [1:0] ADDR_BUF  = 2'b00;
  localparam logic [1:0] ADDR_STAT = 2'b01;
  localparam logic [1:0] ADDR_DBL  = 2'b10;
  localparam logic [1:0] ADDR_DBH  = 2'b11;

  // 50 MHz clock, 19200 baud, 16x oversampling.
  localparam logic [15:0] DB_RESET_DEF = 16'd162;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/spart_baud_gen.sv
// Baud tick generator: divisor registers plus a reloading down-counter.
// The tick fires when the counter is 0, so the period is divisor+1 cycles.
module spart_baud_gen
  import spart_pkg::*;
#(
  parameter logic [15:0] DB_RESET = DB_RESET_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_wr_dbl,
  input  logic       i_wr_dbh,
  input  logic [7:0] i_data,
  output logic       o_tick
);

  logic [15:0] r_divisor;
  logic [15:0] r_cnt;
  logic [15:0] w_divisor_next;

  // Merge a divisor byte write into the current divisor.
  always_comb begin
    w_divisor_next = r_divisor;
    if (i_wr_dbl) w_divisor_next[7:0]  = i_data;
    if (i_wr_dbh) w_divisor_next[15:8] = i_data;
  end

  // Divisor storage and down-counter; a divisor write restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_divisor <= DB_RESET;
      r_cnt     <= DB_RESET;
    end else begin
      r_divisor <= w_divisor_next;
      if (i_wr_dbl || i_wr_dbh || (r_cnt == 16'd0))
        r_cnt <= w_divisor_next;
      else
        r_cnt <= r_cnt - 16'd1;
    end
  end

  assign o_tick = (r_cnt == 16'd0);

endmodule

// File: rtl/spart_core.sv
// SPART serial engine: bus access decode, 8N1 transmitter and
// 16x-oversampled receiver driven by the shared baud tick.
//
// state    | meaning
// TX_IDLE  | line high; waits for a byte, then the next tick
// TX_START | drives the start bit (0) for OVERSAMPLE ticks
// TX_DATA  | drives 8 data bits LSB first, OVERSAMPLE ticks each
// TX_STOP  | drives the stop bit (1); tbr returns on its last tick
// RX_IDLE  | waits for rxd = 0 on a tick
// RX_START | confirms the start bit at its middle, else glitch
// RX_DATA  | samples 8 bits mid-bit into the shift register
// RX_STOP  | samples the stop bit; a good stop publishes the byte
module spart_core
  import spart_pkg::*;
#(
  parameter logic [15:0] DB_RESET   = DB_RESET_DEF,
  parameter int          OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       tbr,
  output logic       rda,
  output logic       txd,
  input  logic       rxd
);

  localparam int             TW      = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0]  LAST    = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0]  HALF_M1 = TW'(OVERSAMPLE / 2 - 1);

  logic w_wr_tx, w_rd_rx, w_wr_dbl, w_wr_dbh, w_tick;

  assign w_wr_tx  = iocs & ~iorw & (ioaddr == ADDR_BUF);
  assign w_rd_rx  = iocs &  iorw & (ioaddr == ADDR_BUF);
  assign w_wr_dbl = iocs & ~iorw & (ioaddr == ADDR_DBL);
  assign w_wr_dbh = iocs & ~iorw & (ioaddr == ADDR_DBH);

  spart_baud_gen #(.DB_RESET(DB_RESET)) u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_wr_dbl (w_wr_dbl),
    .i_wr_dbh (w_wr_dbh),
    .i_data   (data_in),
    .o_tick   (w_tick)
  );

  // ---------------- transmitter ----------------
  tx_state_t     r_tx_state, w_tx_next;
  logic [TW-1:0] r_tx_tick, w_tx_tick_next;
  logic [2:0]    r_tx_idx, w_tx_idx_next;
  logic [9:0]    r_frame, w_frame_next;
  logic          r_tbr, w_tbr_next;
  logic          r_txd, w_txd_next;
  logic [7:0]    w_tx_data;

  // Transmit state register; txd is registered to keep the pin glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state <= TX_IDLE;
      r_tx_tick  <= '0;
      r_tx_idx   <= '0;
      r_frame    <= 10'h3FF;
      r_tbr      <= 1'b1;
      r_txd      <= 1'b1;
    end else begin
      r_tx_state <= w_tx_next;
      r_tx_tick  <= w_tx_tick_next;
      r_tx_idx   <= w_tx_idx_next;
      r_frame    <= w_frame_next;
      r_tbr      <= w_tbr_next;
      r_txd      <= w_txd_next;
    end
  end

  // Transmit next-state: a byte is accepted only while tbr is high.
  always_comb begin
    w_tx_next      = r_tx_state;
    w_tx_tick_next = r_tx_tick;
    w_tx_idx_next  = r_tx_idx;
    w_frame_next   = r_frame;
    w_tbr_next     = r_tbr;
    unique case (r_tx_state)
      TX_IDLE: begin
        if (r_tbr) begin
          if (w_wr_tx) begin
            w_frame_next = {1'b1, data_in, 1'b0};
            w_tbr_next   = 1'b0;
          end
        end else if (w_tick) begin
          w_tx_next      = TX_START;
          w_tx_tick_next = '0;
        end
      end
      TX_START: begin
        if (w_tick) begin
          if (r_tx_tick == LAST) begin
            w_tx_next      = TX_DATA;
            w_tx_tick_next = '0;
            w_tx_idx_next  = '0;
          end else begin
            w_tx_tick_next = r_tx_tick + TW'(1);
          end
        end
      end
      TX_DATA: begin
        if (w_tick) begin
          if (r_tx_tick == LAST) begin
            w_tx_tick_next = '0;
            if (r_tx_idx == 3'd7) w_tx_next     = TX_STOP;
            else                  w_tx_idx_next = r_tx_idx + 3'd1;
          end else begin
            w_tx_tick_next = r_tx_tick + TW'(1);
          end
        end
      end
      TX_STOP: begin
        if (w_tick) begin
          if (r_tx_tick == LAST) begin
            w_tx_next      = TX_IDLE;
            w_tx_tick_next = '0;
            w_tbr_next     = 1'b1;
          end else begin
            w_tx_tick_next = r_tx_tick + TW'(1);
          end
        end
      end
      default: w_tx_next = TX_IDLE;
    endcase

    w_tx_data = w_frame_next[8:1];
    unique case (w_tx_next)
      TX_START: w_txd_next = w_frame_next[0];
      TX_DATA:  w_txd_next = w_tx_data[w_tx_idx_next];
      TX_STOP:  w_txd_next = w_frame_next[9];
      default:  w_txd_next = 1'b1;
    endcase
  end

  assign tbr = r_tbr;
  assign txd = r_txd;

  // ---------------- receiver ----------------
  logic          r_rx_s1, r_rx_s2;
  rx_state_t     r_rx_state, w_rx_next;
  logic [TW-1:0] r_rx_tick, w_rx_tick_next;
  logic [2:0]    r_rx_idx, w_rx_idx_next;
  logic [7:0]    r_shift, w_shift_next;
  logic [7:0]    r_data_out, w_data_out_next;
  logic          r_rda, w_rda_next;

  // Two-flop synchroniser for the asynchronous rxd pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
    end else begin
      r_rx_s1 <= rxd;
      r_rx_s2 <= r_rx_s1;
    end
  end

  // Receive state register and the published byte / rda flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_state <= RX_IDLE;
      r_rx_tick  <= '0;
      r_rx_idx   <= '0;
      r_shift    <= '0;
      r_data_out <= '0;
      r_rda      <= 1'b0;
    end else begin
      r_rx_state <= w_rx_next;
      r_rx_tick  <= w_rx_tick_next;
      r_rx_idx   <= w_rx_idx_next;
      r_shift    <= w_shift_next;
      r_data_out <= w_data_out_next;
      r_rda      <= w_rda_next;
    end
  end

  // Receive next-state; a completed byte overrides a same-cycle read clear.
  always_comb begin
    w_rx_next       = r_rx_state;
    w_rx_tick_next  = r_rx_tick;
    w_rx_idx_next   = r_rx_idx;
    w_shift_next    = r_shift;
    w_data_out_next = r_data_out;
    w_rda_next      = r_rda;
    if (w_rd_rx) w_rda_next = 1'b0;
    unique case (r_rx_state)
      RX_IDLE: begin
        if (w_tick && !r_rx_s2) begin
          w_rx_next      = RX_START;
          w_rx_tick_next = '0;
        end
      end
      RX_START: begin
        if (w_tick) begin
          if (r_rx_tick == HALF_M1) begin
            w_rx_tick_next = '0;
            if (r_rx_s2) begin
              w_rx_next = RX_IDLE;
            end else begin
              w_rx_next     = RX_DATA;
              w_rx_idx_next = '0;
            end
          end else begin
            w_rx_tick_next = r_rx_tick + TW'(1);
          end
        end
      end
      RX_DATA: begin
        if (w_tick) begin
          if (r_rx_tick == LAST) begin
            w_rx_tick_next = '0;
            w_shift_next   = {r_rx_s2, r_shift[7:1]};
            if (r_rx_idx == 3'd7) w_rx_next     = RX_STOP;
            else                  w_rx_idx_next = r_rx_idx + 3'd1;
          end else begin
            w_rx_tick_next = r_rx_tick + TW'(1);
          end
        end
      end
      RX_STOP: begin
        if (w_tick) begin
          if (r_rx_tick == LAST) begin
            w_rx_next      = RX_IDLE;
            w_rx_tick_next = '0;
            if (r_rx_s2) begin
              w_data_out_next = r_shift;
              w_rda_next      = 1'b1;
            end
          end else begin
            w_rx_tick_next = r_rx_tick + TW'(1);
          end
        end
      end
      default: w_rx_next = RX_IDLE;
    endcase
  end

  assign data_out = r_data_out;
  assign rda      = r_rda;

endmodule

// File: doc/spart_core.md
Name: spart_core

Overview:
- Serial engine behind the SPART processor-side bus interface.
- Produces `tbr`/`rda` status flags, accepts transmit bytes written from the internal data bus, and presents received bytes for reads.
- Contains the baud divisor registers (DB low/high), the 16x-oversampled receiver and the transmitter.
- Sits between the bus interface (toward the CPU) and the TXD/RXD pins.

Parameters:
- DB_RESET, 16'd162, divisor loaded at reset (50 MHz clk, 19200 baud, 16x oversample).
- OVERSAMPLE, 16, baud ticks per serial bit; must be a power of two, at least 8.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- iocs  input  1  I/O chip select; high for exactly one cycle per access
- iorw  input  1  1 = read, 0 = write
- ioaddr  input  2  00 = Tx/Rx buffer, 01 = status (handled upstream), 10 = DB low, 11 = DB high
- data_in  input  8  write data taken from the internal data bus
- data_out  output  8  receive buffer contents; top level drives it onto the internal bus on reads
- tbr  output  1  transmit buffer ready
- rda  output  1  receive data available
- txd  output  1  serial transmit line
- rxd  input  1  serial receive line, asynchronous

Behaviour:
- Reset and clocking: one clock `clk`; reset is asynchronous and active-low on `rst_n`.
- Reset values:
  - txd = 1, tbr = 1, rda = 0, data_out = 8'h00.
  - divisor = DB_RESET; both FSMs IDLE; rxd synchroniser flops = 1.
- Access decode, all single-cycle and sampled on the rising edge with iocs = 1:
  - wr_tx = !iorw & addr 00; rd_rx = iorw & addr 00; wr_dbl = !iorw & addr 10; wr_dbh = !iorw & addr 11.
  - Reads at 10/11 and any access at 01 have no effect on this block.
- Baud generator:
  - 16-bit down-counter reloads the divisor on reaching 0 or on any DB write, and emits a 1-cycle `tick` at 0.
  - Tick period = divisor+1 cycles.
  - DB write replaces that byte of the divisor next cycle; an in-flight frame continues at the new rate.
- Transmitter FSM: TX_IDLE -> TX_START -> TX_DATA -> TX_STOP -> TX_IDLE.
  - wr_tx while tbr = 1: latch data_in into a 10-bit frame {1, data, 0}, tbr <= 0, enter TX_START on the next tick.
  - Each state holds txd for OVERSAMPLE ticks. Bits go out LSB first; 8 data bits are counted by a 3-bit index.
  - tbr returns to 1 in the cycle the stop bit's last tick completes.
  - wr_tx while tbr = 0 is ignored: no data change, no error.
- Receiver:
  - rxd passes through a 2-flop synchroniser.
  - FSM: RX_IDLE -> RX_START -> RX_DATA -> RX_STOP -> RX_IDLE.
  - RX_IDLE: a synchronised rxd = 0 seen on a tick enters RX_START with the tick count cleared.
  - RX_START: at tick OVERSAMPLE/2, rxd = 1 is a glitch and returns to RX_IDLE; rxd = 0 restarts the count and enters RX_DATA.
  - RX_DATA: sample every OVERSAMPLE ticks (mid-bit) into a right-shifting register, LSB first, 8 samples.
  - RX_STOP: sample at mid-bit.
    - Stop = 1: data_out <= shift register, rda <= 1.
    - Stop = 0 (framing error): discard the byte, rda and data_out unchanged.
    - Either way return to RX_IDLE.
- rd_rx clears rda the next cycle; data_out holds its value.
- Overrun: a new byte completing while rda = 1 overwrites data_out; rda stays 1.
- Simultaneous rd_rx and byte completion in the same cycle: the new byte is loaded and rda = 1 (set wins).
- Reset asserted mid-frame: all state returns to reset values immediately; a partial Rx frame is lost and txd goes to 1.

Decomposition:
- spart_pkg holds:
  - ioaddr constants ADDR_BUF = 2'b00, ADDR_STAT = 2'b01, ADDR_DBL = 2'b10, ADDR_DBH = 2'b11;
  - tx_state_t and rx_state_t enums;
  - DB_RESET default.
- One natural sub-module: spart_baud_gen (divisor registers, down-counter, tick output). Tx and Rx stay in spart_core.

Test Plan:
- Write DB low = 8'h00 and high = 8'h00, then wr_tx 8'hA5 -> tick every cycle. tbr = 0 next cycle. txd shows start 0, then bits 1,0,1,0,0,1,0,1 (LSB first), then stop 1, each held 16 cycles. tbr = 1 after 160 ticks.
- DB = 0; drive rxd with frame 0x3C (start, 00111100 LSB first, stop 1) at 16 cycles/bit -> rda = 1 and data_out = 8'h3C after mid-stop. rd_rx -> rda = 0 next cycle, data_out remains 8'h3C.
- rxd low pulse of 4 cycles with DB = 0 -> receiver returns to idle, rda stays 0. A following valid 0x81 frame is received correctly.
- Frame 0x55 with stop bit 0 -> rda stays 0, data_out unchanged. Then two back-to-back frames 0x11, 0x22 with no read between -> data_out = 8'h22, rda = 1.
- wr_tx 8'h0F, then wr_tx 8'hF0 while tbr = 0 -> only 0x0F appears on txd. Assert rst_n = 0 mid-data -> txd = 1, tbr = 1, rda = 0 immediately, divisor = 162.
- After reset, no DB writes, wr_tx 8'h01 -> start bit lasts 16 × 163 = 2608 cycles.
